mem_to_wb_stage: RTL and testbench

//  Memory stage of the 5-stage ARM pipeline: consumer of the EX/MEM register outputs (ALUResultM,

---
 rtl/arm_mem_pkg.sv | 27 ++
 rtl/mem_lane_align.sv | 39 +++
 rtl/mem_to_wb_stage.sv | 156 +++++++++++++++
 tb/tb_mem_to_wb_stage.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM pipeline memory stage.
// Byte-enable encodings match what condUnit produces for word, halfword and byte accesses.
package arm_mem_pkg;

  typedef enum logic {MEM_IDLE, MEM_BUSY} mem_state_t;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;

  // Contents of the MEM/WB pipeline register.
  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] alu_out;
    logic [31:0] pc_plus4;
    logic [3:0]  wa3;
    logic        reg_write;
    logic        mem_to_reg;
    logic        pc_src;
    logic        branch_link;
  } memwb_t;

  function automatic logic be_is_byte(input logic [3:0] be);
    return (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) || (be == 4'b1000);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data-memory port: store replication, load extraction
// with zero extension, and misalignment detection. Purely combinational.
module mem_lane_align
  import arm_mem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [3:0]  i_be,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata_rep,
  output logic [31:0] o_rdata_ext,
  output logic        o_misaligned
);

  logic [31:0] w_byte_shift;
  logic [31:0] w_half_shift;

  assign w_byte_shift = i_rdata >> {i_addr_lo, 3'b000};
  assign w_half_shift = i_rdata >> {i_addr_lo[1], 4'b0000};

  // NOTE: every output gets a default before the branches, so no latch is inferred.
  always_comb begin
    o_wdata_rep  = i_wdata;
    o_rdata_ext  = i_rdata;
    o_misaligned = 1'b0;
    if (i_be == BE_WORD) begin
      o_misaligned = (i_addr_lo != 2'd0);
    end else if (i_be == BE_HALF_LO || i_be == BE_HALF_HI) begin
      o_misaligned = (i_be == BE_HALF_LO) ? (i_addr_lo != 2'd0) : (i_addr_lo != 2'd2);
      o_wdata_rep  = {2{i_wdata[15:0]}};
      o_rdata_ext  = {16'h0000, w_half_shift[15:0]};
    end else if (be_is_byte(i_be)) begin
      o_misaligned = (i_be != (4'b0001 << i_addr_lo));
      o_wdata_rep  = {4{i_wdata[7:0]}};
      o_rdata_ext  = {24'h000000, w_byte_shift[7:0]};
    end
  end

endmodule

// File: rtl/mem_to_wb_stage.sv
// Memory stage of the 5-stage ARM pipeline: req/ack data-memory port with a bounded wait,
// pipeline stall while memory is busy, fault reporting, and the MEM/WB register.
module mem_to_wb_stage
  import arm_mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  WA3M,
  input  logic [3:0]  beM,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic        PCSrcM,
  input  logic        branchLinkM,
  input  logic [31:0] PCPlus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stallM,
  output logic        mem_fault,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [31:0] PCPlus4W,
  output logic [3:0]  WA3W,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic        PCSrcW,
  output logic        branchLinkW
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  mem_state_t    r_state, w_state_next;
  logic [TO_W-1:0] r_count, w_count_next;
  memwb_t        r_wb, w_wb_next;
  logic          r_fault, w_fault_next;

  logic        w_access, w_misaligned, w_req, w_stall, w_complete;
  logic [31:0] w_wdata_rep, w_rdata_ext;

  mem_lane_align u_align (
    .i_addr_lo    (ALUResultM[1:0]),
    .i_be         (beM),
    .i_wdata      (WriteDataM),
    .i_rdata      (dmem_rdata),
    .o_wdata_rep  (w_wdata_rep),
    .o_rdata_ext  (w_rdata_ext),
    .o_misaligned (w_misaligned)
  );

  // An access with no byte lanes enabled behaves like a non-memory instruction.
  assign w_access = (MemWriteM | MemtoRegM) & (beM != 4'b0000);

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_req        = 1'b0;
    w_stall      = 1'b0;
    w_complete   = 1'b0;
    w_fault_next = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        if (!w_access) begin
          w_complete = 1'b1;
        end else if (w_misaligned) begin
          w_fault_next = 1'b1;
        end else begin
          w_req = 1'b1;
          if (dmem_ack) begin
            w_complete = 1'b1;
          end else begin
            w_stall      = 1'b1;
            w_state_next = MEM_BUSY;
            w_count_next = TO_W'(1);
          end
        end
      end
      MEM_BUSY: begin
        w_req = 1'b1;
        if (dmem_ack) begin
          w_complete   = 1'b1;
          w_state_next = MEM_IDLE;
          w_count_next = '0;
        end else if (r_count == TO_W'(TIMEOUT)) begin
          // Abandon: the instruction retires as a bubble and the pipeline moves on.
          w_fault_next = 1'b1;
          w_state_next = MEM_IDLE;
          w_count_next = '0;
        end else begin
          w_stall      = 1'b1;
          w_count_next = r_count + TO_W'(1);
        end
      end
      default: begin
        w_state_next = MEM_IDLE;
        w_count_next = '0;
      end
    endcase
  end

  always_comb begin
    w_wb_next = '0;
    if (w_complete) begin
      w_wb_next.read_data   = (MemtoRegM && w_access) ? w_rdata_ext : 32'h0;
      w_wb_next.alu_out     = ALUResultM;
      w_wb_next.pc_plus4    = PCPlus4M;
      w_wb_next.wa3         = WA3M;
      w_wb_next.reg_write   = RegWriteM;
      w_wb_next.mem_to_reg  = MemtoRegM;
      w_wb_next.pc_src      = PCSrcM;
      w_wb_next.branch_link = branchLinkM;
    end
  end

  // Gating with reset lets an asynchronous reset drop the request in the same cycle.
  assign dmem_req   = w_req & ~reset;
  assign stallM     = w_stall & ~reset;
  assign dmem_we    = dmem_req & MemWriteM;
  assign dmem_addr  = dmem_req ? {ALUResultM[31:2], 2'b00} : 32'h0;
  assign dmem_wdata = dmem_we ? w_wdata_rep : 32'h0;
  assign dmem_be    = dmem_req ? beM : 4'b0000;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MEM_IDLE;
      r_count <= '0;
      r_wb    <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_wb    <= w_wb_next;
      r_fault <= w_fault_next;
    end
  end

  assign mem_fault   = r_fault;
  assign ReadDataW   = r_wb.read_data;
  assign ALUOutW     = r_wb.alu_out;
  assign PCPlus4W    = r_wb.pc_plus4;
  assign WA3W        = r_wb.wa3;
  assign RegWriteW   = r_wb.reg_write;
  assign MemtoRegW   = r_wb.mem_to_reg;
  assign PCSrcW      = r_wb.pc_src;
  assign branchLinkW = r_wb.branch_link;

endmodule

// File: tb/tb_mem_to_wb_stage.sv
// Self-checking bench for mem_to_wb_stage: directed scenarios plus randomized instructions
// compared every cycle against a transaction-level model of the memory stage.
module tb_mem_to_wb_stage;

  localparam int TIMEOUT = 16;

  logic        clk, reset;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, dmem_rdata;
  logic [3:0]  WA3M, beM;
  logic        RegWriteM, MemtoRegM, MemWriteM, PCSrcM, branchLinkM, dmem_ack;
  logic        dmem_req, dmem_we, stallM, mem_fault;
  logic [31:0] dmem_addr, dmem_wdata, ReadDataW, ALUOutW, PCPlus4W;
  logic [3:0]  dmem_be, WA3W;
  logic        RegWriteW, MemtoRegW, PCSrcW, branchLinkW;

  mem_to_wb_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M), .beM(beM),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .PCSrcM(PCSrcM), .branchLinkM(branchLinkM), .PCPlus4M(PCPlus4M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .stallM(stallM), .mem_fault(mem_fault),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .PCPlus4W(PCPlus4W), .WA3W(WA3W),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW),
    .branchLinkW(branchLinkW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] pc4;
    logic [3:0]  wa3;
    logic [3:0]  be;
    logic        rw, m2r, mw, pcs, bl;
  } instr_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Expected values published by the driver for the compare process.
  logic        chk_en = 1'b0;
  logic        e_req, e_we, e_stall, e_fault;
  logic [31:0] e_addr, e_wdata, e_rd, e_alu, e_pc4;
  logic [3:0]  e_be, e_wa3;
  logic        e_rw, e_m2r, e_pcs, e_bl;

  // ---------------- behavioural model helpers ----------------
  function automatic int lowest_lane(input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) return i;
    return 0;
  endfunction

  // An access is aligned when its first enabled lane is the one the address points at.
  function automatic logic is_misaligned(input logic [3:0] be, input logic [31:0] a);
    return (be != 4'b0000) && (lowest_lane(be) != int'(a[1:0]));
  endfunction

  function automatic logic [31:0] replicate(input logic [3:0] be, input logic [31:0] d);
    int n = $countones(be);
    if (n == 1) return {24'h0, d[7:0]} * 32'h01010101;
    if (n == 2) return {16'h0, d[15:0]} * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] load_value(input logic [3:0] be, input logic [31:0] a,
                                             input logic [31:0] r);
    int n = $countones(be);
    if (n == 1) return (r >> (8 * int'(a[1:0]))) & 32'h000000FF;
    if (n == 2) return (r >> (16 * int'(a[1]))) & 32'h0000FFFF;
    return r;
  endfunction

  // ---------------- compare process ----------------
  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      check("ReadDataW",   ReadDataW,   e_rd);
      check("ALUOutW",     ALUOutW,     e_alu);
      check("PCPlus4W",    PCPlus4W,    e_pc4);
      check("WA3W",        WA3W,        e_wa3);
      check("RegWriteW",   RegWriteW,   e_rw);
      check("MemtoRegW",   MemtoRegW,   e_m2r);
      check("PCSrcW",      PCSrcW,      e_pcs);
      check("branchLinkW", branchLinkW, e_bl);
      check("mem_fault",   mem_fault,   e_fault);
    end
    @(negedge clk);
    if (chk_en) begin
      check("dmem_req",   dmem_req,   e_req);
      check("dmem_we",    dmem_we,    e_we);
      check("dmem_addr",  dmem_addr,  e_addr);
      check("dmem_wdata", dmem_wdata, e_wdata);
      check("dmem_be",    dmem_be,    e_be);
      check("stallM",     stallM,     e_stall);
    end
  end

  // ---------------- driver ----------------
  // Presents one EX/MEM instruction, held while stalled. The memory acks d cycles after
  // the first request cycle (d=0: same cycle); d > TIMEOUT means it never acks.
  // Called and returns at posedge+2.
  task automatic run_instr(input instr_t in, input int d, input logic [31:0] rdata,
                           output int stall_cnt, output int req_cnt,
                           output logic [31:0] s_addr, output logic [31:0] s_wdata,
                           output logic [3:0] s_be, output logic s_we);
    logic access, mis, ok, tout, done;
    int   k_end;
    access = (in.mw || in.m2r) && (in.be != 4'b0000);
    mis    = access && is_misaligned(in.be, in.alu);
    ok     = access && !mis;
    tout   = ok && (d > TIMEOUT);
    k_end  = ok ? ((d < TIMEOUT) ? d : TIMEOUT) : 0;
    stall_cnt = 0;
    req_cnt   = 0;
    s_addr = '0; s_wdata = '0; s_be = '0; s_we = 1'b0;
    for (int k = 0; k <= k_end; k++) begin
      ALUResultM  = in.alu;  WriteDataM = in.wdata; PCPlus4M = in.pc4;
      WA3M        = in.wa3;  beM        = in.be;
      RegWriteM   = in.rw;   MemtoRegM  = in.m2r;   MemWriteM = in.mw;
      PCSrcM      = in.pcs;  branchLinkM = in.bl;
      dmem_ack    = ok ? (k == d) : 1'($urandom_range(0, 1));
      dmem_rdata  = (ok && k == d) ? rdata : $urandom();

      e_req   = ok;
      e_we    = ok && in.mw;
      e_addr  = ok ? (in.alu & 32'hFFFF_FFFC) : 32'h0;
      e_wdata = e_we ? replicate(in.be, in.wdata) : 32'h0;
      e_be    = ok ? in.be : 4'b0000;
      e_stall = ok && (k < k_end);

      done = (k == k_end) && !mis && !tout;
      e_rd  = (done && ok && in.m2r) ? load_value(in.be, in.alu, rdata) : 32'h0;
      e_alu = done ? in.alu : 32'h0;
      e_pc4 = done ? in.pc4 : 32'h0;
      e_wa3 = done ? in.wa3 : 4'h0;
      e_rw  = done && in.rw;
      e_m2r = done && in.m2r;
      e_pcs = done && in.pcs;
      e_bl  = done && in.bl;
      e_fault = (k == k_end) && (mis || tout);
      chk_en  = 1'b1;

      #1;
      if (stallM)   stall_cnt++;
      if (dmem_req) req_cnt++;
      if (k == 0) begin
        s_addr = dmem_addr; s_wdata = dmem_wdata; s_be = dmem_be; s_we = dmem_we;
      end
      @(posedge clk);
      #2;
    end
  endtask

  function automatic instr_t mk(input logic [31:0] alu, input logic [3:0] be,
                                input logic load, input logic store, input logic [31:0] wdata);
    instr_t t;
    t       = '0;
    t.alu   = alu;
    t.be    = be;
    t.m2r   = load;
    t.mw    = store;
    t.rw    = load;
    t.wdata = wdata;
    t.wa3   = 4'd5;
    t.pc4   = alu + 32'h40;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t      t;
    int          sc, rc, d;
    logic [31:0] sa, sw, rdv;
    logic [3:0]  sb;
    logic        swe;
    logic [3:0]  be_tab [8];
    be_tab = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

    // Reset with a load presented: request and stall must stay low.
    reset = 1'b1;
    ALUResultM = 32'h100; WriteDataM = '0; PCPlus4M = '0; WA3M = '0; beM = 4'b1111;
    RegWriteM = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0; PCSrcM = 1'b0; branchLinkM = 1'b0;
    dmem_rdata = '0; dmem_ack = 1'b0;
    #1;
    check("rst_req",   dmem_req,  0);
    check("rst_stall", stallM,    0);
    check("rst_rd",    ReadDataW, 0);
    check("rst_rw",    RegWriteW, 0);
    check("rst_fault", mem_fault, 0);
    @(posedge clk); #2;
    MemtoRegM = 1'b0; RegWriteM = 1'b0; beM = 4'b0000; ALUResultM = '0;
    reset = 1'b0;
    @(posedge clk); #2;

    // 1: word load, ack in the request cycle.
    t = mk(32'h100, 4'b1111, 1'b1, 1'b0, 32'h0);
    run_instr(t, 0, 32'hDEADBEEF, sc, rc, sa, sw, sb, swe);
    check("t1_stall", sc, 0);
    check("t1_rd",    ReadDataW, 32'hDEADBEEF);
    check("t1_rw",    RegWriteW, 1);

    // 2: byte load from lane 3, ack three cycles late.
    t = mk(32'h103, 4'b1000, 1'b1, 1'b0, 32'h0);
    run_instr(t, 3, 32'hAB112233, sc, rc, sa, sw, sb, swe);
    check("t2_stall", sc, 3);
    check("t2_rd",    ReadDataW, 32'h000000AB);

    // 3: upper halfword store.
    t = mk(32'h202, 4'b1100, 1'b0, 1'b1, 32'h1234CAFE);
    run_instr(t, 1, 32'h0, sc, rc, sa, sw, sb, swe);
    check("t3_wdata", sw,  32'hCAFECAFE);
    check("t3_be",    sb,  4'b1100);
    check("t3_addr",  sa,  32'h200);
    check("t3_we",    swe, 1);
    check("t3_rd",    ReadDataW, 0);

    // 4: misaligned word load.
    t = mk(32'h101, 4'b1111, 1'b1, 1'b0, 32'h0);
    run_instr(t, 0, 32'h0, sc, rc, sa, sw, sb, swe);
    check("t4_req",   rc, 0);
    check("t4_stall", sc, 0);
    check("t4_fault", mem_fault, 1);
    check("t4_rw",    RegWriteW, 0);
    t = mk(32'h0, 4'b0000, 1'b0, 1'b0, 32'h0);
    run_instr(t, 0, 32'h0, sc, rc, sa, sw, sb, swe);
    check("t4_pulse", mem_fault, 0);

    // 5: load that is never acknowledged.
    t = mk(32'h400, 4'b1111, 1'b1, 1'b0, 32'h0);
    run_instr(t, 1000, 32'h0, sc, rc, sa, sw, sb, swe);
    check("t5_stall", sc, TIMEOUT);
    check("t5_fault", mem_fault, 1);
    check("t5_rw",    RegWriteW, 0);
    t = mk(32'h8, 4'b0000, 1'b0, 1'b0, 32'h0);
    run_instr(t, 0, 32'h0, sc, rc, sa, sw, sb, swe);
    check("t5_req_after", rc, 0);
    check("t5_pulse",     mem_fault, 0);

    // Randomized instruction stream.
    for (int n = 0; n < 300; n++) begin
      int kind;
      t       = '0;
      t.alu   = $urandom();
      t.wdata = $urandom();
      t.pc4   = $urandom();
      t.wa3   = 4'($urandom_range(0, 15));
      t.be    = be_tab[$urandom_range(0, 7)];
      t.pcs   = 1'($urandom_range(0, 1));
      t.bl    = 1'($urandom_range(0, 1));
      kind    = $urandom_range(0, 9);
      if (kind < 4) begin
        t.rw = 1'($urandom_range(0, 1));
      end else if (kind < 7) begin
        t.m2r = 1'b1; t.rw = 1'b1;
      end else begin
        t.mw = 1'b1;
      end
      if ($urandom_range(0, 4) != 0) t.alu[1:0] = 2'(lowest_lane(t.be));
      kind = $urandom_range(0, 19);
      if (kind < 14)      d = kind % 4;
      else if (kind < 17) d = $urandom_range(4, TIMEOUT - 1);
      else if (kind == 17) d = TIMEOUT;
      else                d = TIMEOUT + 1 + $urandom_range(0, 3);
      rdv = $urandom();
      run_instr(t, d, rdv, sc, rc, sa, sw, sb, swe);
    end

    // 6: reset during the second BUSY cycle.
    chk_en = 1'b0;
    ALUResultM = 32'h300; beM = 4'b1111; MemtoRegM = 1'b1; RegWriteM = 1'b1;
    MemWriteM = 1'b0; PCSrcM = 1'b0; branchLinkM = 1'b0; WA3M = 4'd2; PCPlus4M = 32'h304;
    dmem_ack = 1'b0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("t6_busy_req", dmem_req, 1);
    reset = 1'b1;
    #1;
    check("t6_req",   dmem_req,  0);
    check("t6_stall", stallM,    0);
    check("t6_rd",    ReadDataW, 0);
    check("t6_alu",   ALUOutW,   0);
    check("t6_rw",    RegWriteW, 0);
    check("t6_fault", mem_fault, 0);
    MemtoRegM = 1'b0; RegWriteM = 1'b0; beM = 4'b0000; ALUResultM = '0;
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;
    t = mk(32'h500, 4'b1111, 1'b1, 1'b0, 32'h0);
    run_instr(t, 1000, 32'h0, sc, rc, sa, sw, sb, swe);
    check("t6_to_stall", sc, TIMEOUT);
    t = mk(32'h502, 4'b0011 << 2, 1'b1, 1'b0, 32'h0);
    run_instr(t, 2, 32'h5555AAAA, sc, rc, sa, sw, sb, swe);
    check("t6_rd_after", ReadDataW, 32'h00005555);
    check("t6_stall_after", sc, 2);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
